// File: rtl/tv80_blkmov.sv
// -----------------------------------------------------------------------------
// tv80_blkmov
// Block-transfer sequencer for the TV80 core (LDI/LDD/LDIR/LDDR).
// A start pulse snapshots BC/DE/HL. Each iteration copies one byte from
// memory[HL] to memory[DE] over a req/ack bus, steps HL/DE/BC, and writes
// BC, DE and HL back through the register-file write port.
//
// Optional build macro: TV80_BLKMOV_INT_EN
//   When defined, adds input int_req and output irq_break. int_req is
//   sampled at the last write-back cycle of a repeat transfer and ends the
//   transfer early, leaving a resumable BC/DE/HL in the register file.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, mode[1:0]      start pulse; mode[0]=decrement, mode[1]=repeat
//   bc_in/de_in/hl_in     register pairs sampled at start
//   mem_req/we/addr/wdata memory request bus (held until mem_ack)
//   mem_rdata, mem_ack    memory response
//   wb_addr/dih/dil/we    register-file write port (0=BC, 1=DE, 2=HL)
//   busy, done, pv        status; pv = final BC != 0
//   int_req, irq_break    interrupt break (TV80_BLKMOV_INT_EN only)
// -----------------------------------------------------------------------------
module tv80_blkmov #(
    parameter int unsigned WB_PAIRS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] bc_in,
    input  logic [15:0] de_in,
    input  logic [15:0] hl_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_dih,
    output logic [7:0]  wb_dil,
    output logic        wb_we,
    output logic        busy,
    output logic        done,
    output logic        pv
`ifdef TV80_BLKMOV_INT_EN
    ,
    input  logic        int_req,
    output logic        irq_break
`endif
);

    localparam int unsigned PW  = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned WAW = 3;
    localparam int unsigned IW  = 2;
    localparam logic [IW-1:0] WB_LAST = IW'(WB_PAIRS - 1);

    // S_WB covers the three write-back cycles, indexed by wb_idx.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_GAP,
        S_WR,
        S_UPD,
        S_WB,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [1:0]     mode_q, mode_n;
    logic [PW-1:0]  bc_q, bc_n;
    logic [PW-1:0]  de_q, de_n;
    logic [PW-1:0]  hl_q, hl_n;
    logic [DW-1:0]  data_q, data_n;
    logic [IW-1:0]  wb_idx, wb_idx_n;
    logic           irq_q, irq_n;
    logic           pv_n;
    logic           brk_c;

    logic           mem_req_n, mem_we_n, wb_we_n, busy_n, done_n;
    logic [PW-1:0]  mem_addr_n;
    logic [DW-1:0]  mem_wdata_n;
    logic [WAW-1:0] wb_addr_n;
    logic [PW-1:0]  wb_pair_n;

    // Interrupt break request, tied off when the feature is not built.
`ifdef TV80_BLKMOV_INT_EN
    assign brk_c     = int_req;
    assign irq_break = irq_q;
`else
    assign brk_c     = 1'b0;
`endif

    // State and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            bc_q      <= '0;
            de_q      <= '0;
            hl_q      <= '0;
            data_q    <= '0;
            wb_idx    <= '0;
            irq_q     <= 1'b0;
            pv        <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_we     <= 1'b0;
            wb_addr   <= '0;
            wb_dih    <= '0;
            wb_dil    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            bc_q      <= bc_n;
            de_q      <= de_n;
            hl_q      <= hl_n;
            data_q    <= data_n;
            wb_idx    <= wb_idx_n;
            irq_q     <= irq_n;
            pv        <= pv_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            wb_we     <= wb_we_n;
            wb_addr   <= wb_addr_n;
            wb_dih    <= wb_pair_n[15:8];
            wb_dil    <= wb_pair_n[7:0];
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        bc_n     = bc_q;
        de_n     = de_q;
        hl_n     = hl_q;
        data_n   = data_q;
        wb_idx_n = wb_idx;
        irq_n    = irq_q;
        pv_n     = pv;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    bc_n    = bc_in;
                    de_n    = de_in;
                    hl_n    = hl_in;
                    pv_n    = 1'b0;
                    irq_n   = 1'b0;
                    state_n = S_RD;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    data_n  = mem_rdata;
                    state_n = S_GAP;
                end
            end
            // Forces mem_req low for one cycle between read and write.
            S_GAP: state_n = S_WR;
            S_WR: begin
                if (mem_ack) begin
                    state_n = S_UPD;
                end
            end
            S_UPD: begin
                bc_n = bc_q - 16'd1;
                if (mode_q[0]) begin
                    hl_n = hl_q - 16'd1;
                    de_n = de_q - 16'd1;
                end else begin
                    hl_n = hl_q + 16'd1;
                    de_n = de_q + 16'd1;
                end
                wb_idx_n = '0;
                state_n  = S_WB;
            end
            S_WB: begin
                if (wb_idx == WB_LAST) begin
                    if (mode_q[1] && (bc_q != '0) && !brk_c) begin
                        state_n = S_RD;
                    end else begin
                        pv_n    = (bc_q != '0);
                        irq_n   = mode_q[1] && (bc_q != '0) && brk_c;
                        state_n = S_DONE;
                    end
                end else begin
                    wb_idx_n = wb_idx + 2'd1;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so they are registered.
    always_comb begin
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        wb_we_n     = 1'b0;
        wb_addr_n   = wb_addr;
        wb_pair_n   = {wb_dih, wb_dil};
        done_n      = 1'b0;
        busy_n      = (state_n != S_IDLE);

        unique case (state_n)
            S_RD: begin
                mem_req_n  = 1'b1;
                mem_addr_n = hl_n;
            end
            S_WR: begin
                mem_req_n   = 1'b1;
                mem_we_n    = 1'b1;
                mem_addr_n  = de_n;
                mem_wdata_n = data_n;
            end
            S_WB: begin
                wb_we_n   = 1'b1;
                wb_addr_n = WAW'(wb_idx_n);
                case (wb_idx_n)
                    2'd0:    wb_pair_n = bc_n;
                    2'd1:    wb_pair_n = de_n;
                    default: wb_pair_n = hl_n;
                endcase
            end
            S_DONE: done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tv80_blkmov.sv
// -----------------------------------------------------------------------------
// tb_tv80_blkmov
// Bench for tv80_blkmov: memory responder with configurable wait states,
// write-back monitor, and a model that predicts bus and write-back traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tv80_blkmov;

    typedef struct packed { logic we; logic [15:0] addr; logic [7:0] data; } bus_t;
    typedef struct packed { logic [2:0] addr; logic [15:0] val; } wb_t;

    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] bc_in = '0, de_in = '0, hl_in = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_dih, wb_dil;
    logic        wb_we, busy, done, pv;
`ifdef TV80_BLKMOV_INT_EN
    logic        int_req;
    logic        irq_break;
    logic        int_arm = 1'b0;
`endif

    logic [7:0] mem [0:65535];
    logic [7:0] mdl [0:65535];
    bus_t exp_bus[$], act_bus[$];
    wb_t  exp_wb[$],  act_wb[$];

    int   wait_cfg = 0, wcnt = 0, stab_err = 0, gap_err = 0, wb_seen = 0;
    int   cyc = 0, last_wb_cyc = 0, done_cyc = 0;
    logic prev_ack = 1'b0;
    bus_t first_req;
    int   n_checks = 0, n_fail = 0;

    tv80_blkmov #(.WB_PAIRS(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .bc_in     (bc_in),
        .de_in     (de_in),
        .hl_in     (hl_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_addr   (wb_addr),
        .wb_dih    (wb_dih),
        .wb_dil    (wb_dil),
        .wb_we     (wb_we),
        .busy      (busy),
        .done      (done),
        .pv        (pv)
`ifdef TV80_BLKMOV_INT_EN
        ,
        .int_req   (int_req),
        .irq_break (irq_break)
`endif
    );

`ifdef TV80_BLKMOV_INT_EN
    // Raised from the first write-back of the second iteration onward.
    assign int_req = int_arm && (wb_seen >= 4);
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory responder: ack after wait_cfg extra request cycles.
    always @(negedge clk) begin
        if (reset_n && mem_req) begin
            if (prev_ack) gap_err++;
            if (wcnt == 0) first_req = {mem_we, mem_addr, mem_wdata};
            else if (first_req.we !== mem_we || first_req.addr !== mem_addr ||
                     (mem_we && first_req.data !== mem_wdata)) stab_err++;
            if (wcnt >= wait_cfg) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    act_bus.push_back({1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem[mem_addr];
                    act_bus.push_back({1'b0, mem_addr, mem[mem_addr]});
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
        prev_ack = mem_ack;
    end

    // Write-back monitor.
    always @(negedge clk) begin
        if (reset_n && wb_we) begin
            act_wb.push_back({wb_addr, wb_dih, wb_dil});
            wb_seen++;
            last_wb_cyc = cyc;
        end
    end

    task automatic mem_set(input logic [15:0] a, input logic [7:0] v);
        mem[a] = v;
        mdl[a] = v;
    endtask

    // Model: push expected bus transactions and write-backs.
    task automatic expect_xfer(input logic [1:0] m, input logic [15:0] b, d, h,
                               input int max_it);
        logic [15:0] fb, fd, fh;
        int it;
        fb = b; fd = d; fh = h; it = 0;
        do begin
            exp_bus.push_back({1'b0, fh, mdl[fh]});
            exp_bus.push_back({1'b1, fd, mdl[fh]});
            mdl[fd] = mdl[fh];
            fb = fb - 16'd1;
            if (m[0]) begin fh = fh - 16'd1; fd = fd - 16'd1; end
            else      begin fh = fh + 16'd1; fd = fd + 16'd1; end
            exp_wb.push_back({3'd0, fb});
            exp_wb.push_back({3'd1, fd});
            exp_wb.push_back({3'd2, fh});
            it++;
        end while (m[1] && fb != 16'd0 && it < max_it);
    endtask

    // Start a transfer and wait for done; inj>0 pulses start again at that cycle.
    task automatic do_xfer(input logic [1:0] m, input logic [15:0] b, d, h, input int inj,
                           output int lat, output logic got, output logic pv_o);
        @(negedge clk);
        mode = m; bc_in = b; de_in = d; hl_in = h; start = 1'b1;
        lat = 0; got = 1'b0; pv_o = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            start = (lat == inj);
            mode = ~m; bc_in = 16'hBEEF; de_in = 16'hCAFE; hl_in = 16'hF00D;
            if (done) begin got = 1'b1; pv_o = pv; done_cyc = cyc; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_addr, wb_dih, wb_dil, wb_we, busy, done, pv} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual req=%b we=%b addr=%h wd=%h wba=%h wb=%h%h wbwe=%b busy=%b done=%b pv=%b required all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, wb_addr, wb_dih, wb_dil, wb_we, busy, done, pv);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: actual req=%b busy=%b required 0 0", mem_req, busy);
        end
    endtask

    task automatic test_ldi();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        mem_set(16'h1000, 8'hA5); mem_set(16'h2000, 8'h00);
        expect_xfer(2'b00, 16'h0003, 16'h2000, 16'h1000, 1);
        do_xfer(2'b00, 16'h0003, 16'h2000, 16'h1000, 0, lat, got, pvo);
        n_checks++;
        if (!got || lat != 8) begin n_fail++; $display("FAIL ldi_latency: actual got=%b lat=%0d required 1 8", got, lat); end
        n_checks++;
        if (pvo !== 1'b1) begin n_fail++; $display("FAIL ldi_pv: actual %b required 1", pvo); end
        n_checks++;
        if (done_cyc - last_wb_cyc != 1) begin n_fail++; $display("FAIL ldi_done_after_wb2: actual %0d required 1", done_cyc - last_wb_cyc); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ldi_busy_at_done: actual %b required 1", busy); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pv !== 1'b1) begin
            n_fail++; $display("FAIL ldi_after_done: actual busy=%b done=%b pv=%b required 0 0 1", busy, done, pv);
        end
        n_checks++;
        if (mem[16'h2000] !== 8'hA5) begin n_fail++; $display("FAIL ldi_mem: actual %h required a5", mem[16'h2000]); end
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL ldi_bus: actual %h required %h", ab, eb); end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL ldi_wb: actual %h required %h", aw, ew); end
        end
    endtask

    task automatic test_ldir();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        mem_set(16'h1000, 8'h11); mem_set(16'h1001, 8'h22);
        mem_set(16'h1002, 8'h33); mem_set(16'h1003, 8'h44);
        expect_xfer(2'b10, 16'h0004, 16'h2000, 16'h1000, 100);
        do_xfer(2'b10, 16'h0004, 16'h2000, 16'h1000, 0, lat, got, pvo);
        n_checks++;
        if (!got || lat != 29 || pvo !== 1'b0) begin
            n_fail++; $display("FAIL ldir_done: actual got=%b lat=%0d pv=%b required 1 29 0", got, lat, pvo);
        end
        n_checks++;
        if ({mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]} !== 32'h11223344) begin
            n_fail++; $display("FAIL ldir_mem: actual %h%h%h%h required 11223344",
                               mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]);
        end
        n_checks++;
        if (act_bus.size() != 8) begin n_fail++; $display("FAIL ldir_txn_count: actual %0d required 8", act_bus.size()); end
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL ldir_bus: actual %h required %h", ab, eb); end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL ldir_wb: actual %h required %h", aw, ew); end
        end
        n_checks++;
        if (aw !== {3'd2, 16'h1004}) begin n_fail++; $display("FAIL ldir_final_hl: actual %h required 21004", aw); end
    endtask

    task automatic test_lddr_wrap();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        mem_set(16'h0000, 8'h5A); mem_set(16'hFFFF, 8'hC3); mem_set(16'h0001, 8'h00);
        expect_xfer(2'b11, 16'h0002, 16'h0001, 16'h0000, 100);
        do_xfer(2'b11, 16'h0002, 16'h0001, 16'h0000, 0, lat, got, pvo);
        n_checks++;
        if (!got || pvo !== 1'b0) begin n_fail++; $display("FAIL lddr_done: actual got=%b pv=%b required 1 0", got, pvo); end
        n_checks++;
        if ({mem[16'h0001], mem[16'h0000]} !== 16'h5AC3) begin
            n_fail++; $display("FAIL lddr_mem: actual %h%h required 5ac3", mem[16'h0001], mem[16'h0000]);
        end
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL lddr_bus: actual %h required %h", ab, eb); end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL lddr_wb: actual %h required %h", aw, ew); end
        end
        n_checks++;
        if (aw !== {3'd2, 16'hFFFE}) begin n_fail++; $display("FAIL lddr_final_hl: actual %h required 2fffe", aw); end
    endtask

    task automatic test_wait_states();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        wait_cfg = 3;
        mem_set(16'h3000, 8'h01); mem_set(16'h3001, 8'h02); mem_set(16'h3002, 8'h03);
        expect_xfer(2'b10, 16'h0003, 16'h4000, 16'h3000, 100);
        do_xfer(2'b10, 16'h0003, 16'h4000, 16'h3000, 5, lat, got, pvo);
        repeat (10) @(negedge clk);
        n_checks++;
        if (!got || lat != 40) begin n_fail++; $display("FAIL wait_latency: actual got=%b lat=%0d required 1 40", got, lat); end
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL wait_stable: actual %0d required 0", stab_err); end
        n_checks++;
        if (gap_err != 0) begin n_fail++; $display("FAIL req_gap: actual %0d required 0", gap_err); end
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL wait_bus: actual %h required %h", ab, eb); end
        end
        n_checks++;
        if (act_bus.size() != 0) begin n_fail++; $display("FAIL wait_extra_txn: actual %0d required 0", act_bus.size()); end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL wait_wb: actual %h required %h", aw, ew); end
        end
        wait_cfg = 0;
    endtask

    task automatic test_reset_mid();
        int n; int act_cnt;
        wait_cfg = 2;
        mem_set(16'h1000, 8'h77);
        @(negedge clk);
        mode = 2'b10; bc_in = 16'h0004; de_in = 16'h2000; hl_in = 16'h1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < BUDGET) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= BUDGET) begin n_fail++; $display("FAIL rst_reach_wr: actual timeout required write phase"); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, wb_addr, wb_dih, wb_dil, wb_we, busy, done, pv} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: actual req=%b we=%b addr=%h wd=%h busy=%b required all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        act_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || wb_we || busy) act_cnt++;
        end
        n_checks++;
        if (act_cnt != 0) begin n_fail++; $display("FAIL rst_quiet: actual %0d active cycles required 0", act_cnt); end
        exp_bus.delete(); act_bus.delete(); exp_wb.delete(); act_wb.delete();
        wait_cfg = 0;
    endtask

    task automatic test_back_to_back();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        mem_set(16'h5000, 8'h9E); mem_set(16'h6000, 8'h00);
        mem_set(16'h7000, 8'h3C); mem_set(16'h7800, 8'h00);
        expect_xfer(2'b01, 16'h0001, 16'h6000, 16'h5000, 1);
        do_xfer(2'b01, 16'h0001, 16'h6000, 16'h5000, 0, lat, got, pvo);
        n_checks++;
        if (!got || lat != 8 || pvo !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ldd: actual got=%b lat=%0d pv=%b required 1 8 0", got, lat, pvo);
        end
        expect_xfer(2'b00, 16'h0000, 16'h7800, 16'h7000, 1);
        do_xfer(2'b00, 16'h0000, 16'h7800, 16'h7000, 0, lat, got, pvo);
        n_checks++;
        if (!got || lat != 8 || pvo !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ldi_bc0: actual got=%b lat=%0d pv=%b required 1 8 1", got, lat, pvo);
        end
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL b2b_bus: actual %h required %h", ab, eb); end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL b2b_wb: actual %h required %h", aw, ew); end
        end
    endtask

`ifdef TV80_BLKMOV_INT_EN
    task automatic test_int_break();
        int lat; logic got, pvo; bus_t eb, ab; wb_t ew, aw;
        mem_set(16'h8000, 8'hAA); mem_set(16'h8001, 8'hBB);
        wb_seen = 0;
        int_arm = 1'b1;
        expect_xfer(2'b10, 16'h0010, 16'h9000, 16'h8000, 2);
        do_xfer(2'b10, 16'h0010, 16'h9000, 16'h8000, 0, lat, got, pvo);
        n_checks++;
        if (!got || lat != 15 || pvo !== 1'b1 || irq_break !== 1'b1) begin
            n_fail++; $display("FAIL int_break: actual got=%b lat=%0d pv=%b irq=%b required 1 15 1 1",
                               got, lat, pvo, irq_break);
        end
        int_arm = 1'b0;
        while (exp_bus.size() > 0) begin
            eb = exp_bus.pop_front(); ab = '1;
            if (act_bus.size() > 0) ab = act_bus.pop_front();
            n_checks++;
            if (ab !== eb) begin n_fail++; $display("FAIL int_bus: actual %h required %h", ab, eb); end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); aw = '1;
            if (act_wb.size() > 0) aw = act_wb.pop_front();
            n_checks++;
            if (aw !== ew) begin n_fail++; $display("FAIL int_wb: actual %h required %h", aw, ew); end
            if (ew.addr == 3'd0 && ew.val == 16'h000E) begin
                n_checks++;
                if (aw !== {3'd0, 16'h000E}) begin n_fail++; $display("FAIL int_bc: actual %h required 0000e", aw); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ldi();
        test_ldir();
        test_lddr_wrap();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
`ifdef TV80_BLKMOV_INT_EN
        test_int_break();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tv80_blkmov.md
Name: tv80_blkmov

Overview:
- Block-transfer sequencer, directly upstream of the TV80 register file's write port and downstream of its BC/DE/HL pair outputs.
- On a start pulse it snapshots BC/DE/HL and copies bytes from memory[HL] to memory[DE] over a req/ack bus.
- Each iteration it updates HL/DE/BC and writes the new pairs back through the register-file write port.
- Implements LDI/LDD/LDIR/LDDR-style transfers for the Game Boy/Z80 core.

Parameters:
- WB_PAIRS, 3, number of register pairs written back per iteration (index 0=BC, 1=DE, 2=HL); fixed at 3, other values unsupported.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begin transfer; ignored while busy=1
- mode  input  2  sampled at start: bit0=1 decrement (LDD), bit0=0 increment (LDI); bit1=1 repeat until BC==0
- bc_in  input  16  BC pair from register file
- de_in  input  16  DE pair from register file
- hl_in  input  16  HL pair from register file
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1=write, 0=read; valid with mem_req
- mem_addr  output  16  byte address; valid with mem_req
- mem_wdata  output  8  write data; valid with mem_req & mem_we
- mem_rdata  input  8  read data, sampled on the cycle mem_ack=1
- mem_ack  input  1  one-cycle acknowledge; may arrive the same cycle mem_req rises
- wb_addr  output  3  register-file write address (drives AddrA)
- wb_dih  output  8  high byte (drives DIH)
- wb_dil  output  8  low byte (drives DIL)
- wb_we  output  1  drives both WEH and WEL; CEN is assumed high
- busy  output  1  1 from the cycle after start until done
- done  output  1  one-cycle pulse at end of transfer
- pv  output  1  final BC != 0, valid from done until next start

Behaviour:
- Reset: state IDLE; mem_req, mem_we, wb_we, busy, done, pv=0; mem_addr, mem_wdata, wb_addr, wb_dih, wb_dil=0; internal bc/de/hl/data regs=0. Reset mid-transfer aborts immediately with no further bus or write-back activity.
- IDLE: on start, latch mode, bc_in, de_in, hl_in; go RD; busy=1 next cycle.
- RD: mem_req=1, mem_we=0, mem_addr=hl. On mem_ack, latch mem_rdata; go WR.
- WR: mem_req=1, mem_we=1, mem_addr=de, mem_wdata=latched byte. On mem_ack, go UPD.
- mem_req deasserts for at least one cycle between the RD and WR transactions.
- UPD (1 cycle): bc<=bc-1; hl<=hl±1; de<=de±1.
  - All arithmetic is 16-bit modulo: 0xFFFF+1=0x0000, 0x0000-1=0xFFFF.
  - BC=0 at start is a 65536-byte transfer in repeat mode.
- WB0/WB1/WB2 (1 cycle each, wb_we=1): write pair 0=BC, 1=DE, 2=HL.
  - wb_addr=index; wb_dih=pair[15:8]; wb_dil=pair[7:0].
  - wb_we=0 in every other state.
- After WB2:
  - Repeat mode with bc!=0: return to RD.
  - Otherwise go DONE.
- DONE (1 cycle): done=1; pv=(bc!=0); next cycle IDLE, busy=0.
- Per-iteration latency with zero-wait ack (ack on the first req cycle): RD 1 + gap 1 + WR 1 + UPD 1 + WB 3 = 7 cycles.
- start during busy: ignored, no state change.
- bc_in/de_in/hl_in are not re-sampled mid-transfer; the block relies on its internal copies.
- Overlapping source/destination ranges: copied strictly byte-by-byte in address order; no hazard detection.

Optional Feature:
- Macro: TV80_BLKMOV_INT_EN.
- When defined, adds input int_req (1 bit). In repeat mode, int_req is sampled in WB2:
  - If 1, go to DONE even when bc!=0.
  - pv=1 and the output irq_break=1 are asserted with done.
  - The register file then holds the resumable BC/DE/HL.
- When undefined, there is no int_req/irq_break port and repeat runs to BC==0 uninterrupted.

Test Plan:
- LDI: BC=0x0003, HL=0x1000, DE=0x2000, mem[0x1000]=0xA5, zero-wait ack -> mem[0x2000]=0xA5; write-back BC=0x0002, DE=0x2001, HL=0x1001; pv=1; done 1 cycle after WB2.
- LDIR: BC=0x0004, HL=0x1000..0x1003 = 11,22,33,44 -> bytes copied to 0x2000..0x2003; final BC=0, HL=0x1004, DE=0x2004; pv=0; exactly 4 RD/WR pairs.
- LDDR with wrap: BC=0x0002, HL=0x0000, DE=0x0001 -> reads 0x0000 then 0xFFFF; final HL=0xFFFE, DE=0xFFFF, BC=0.
- Wait states: ack delayed 3 cycles on every transaction -> mem_req and mem_addr stable until ack; data correct; start pulse issued mid-transfer is ignored.
- Reset mid-transfer: assert reset_n=0 during WR -> all outputs 0 asynchronously; after release, no mem_req until the next start.
- TV80_BLKMOV_INT_EN: LDIR with BC=0x0010, int_req=1 during the second WB2 -> done with pv=1 and irq_break=1; write-back BC=0x000E.
